// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Baud-rate generator for the UART receiver and transmitter. It divides ACLK by
// an integer-plus-sixteenths divisor to produce a 16x oversampling strobe and a
// 1x bit strobe. An auto-baud engine measures the low time of the start bit of
// an incoming 0x55 character and loads that width, in ACLK cycles, as the new
// divisor. One bit is 16 sample periods, so the bit width in cycles splits
// directly into integer sample cycles (upper bits) and sixteenths (low nibble).
//
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   baud_en                generator enable; low clears and halts the counters
//   div_int, div_frac      software divisor (cycles per sample, 1/16 units)
//   div_load               one-cycle pulse; latch software divisor
//   UART_RX                asynchronous serial line, idle high
//   autobaud_start         one-cycle pulse; arm an auto-baud measurement
//   rx_sample_pulse        16x oversample strobe
//   tx_baud_pulse          1x bit strobe, on every 16th sample strobe
//   autobaud_busy          auto-baud engine not idle
//   autobaud_done/_err     one-cycle result pulses of a measurement
//   div_int_active,
//   div_frac_active        divisor currently used by the generator
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV_INT_WIDTH    = 16,
    parameter int DEFAULT_DIV_INT  = 27,
    parameter int DEFAULT_DIV_FRAC = 2,
    parameter int AB_CNT_WIDTH     = DIV_INT_WIDTH + 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     baud_en,
    input  logic [DIV_INT_WIDTH-1:0] div_int,
    input  logic [3:0]               div_frac,
    input  logic                     div_load,
    input  logic                     UART_RX,
    input  logic                     autobaud_start,
    output logic                     rx_sample_pulse,
    output logic                     tx_baud_pulse,
    output logic                     autobaud_busy,
    output logic                     autobaud_done,
    output logic                     autobaud_err,
    output logic [DIV_INT_WIDTH-1:0] div_int_active,
    output logic [3:0]               div_frac_active
);

    localparam logic [1:0] AB_IDLE      = 2'd0;
    localparam logic [1:0] AB_ARM       = 2'd1;
    localparam logic [1:0] AB_WAIT_FALL = 2'd2;
    localparam logic [1:0] AB_MEASURE   = 2'd3;

    // Shortest accepted start bit: two sample cycles per sample period.
    localparam logic [AB_CNT_WIDTH-1:0] AB_MIN_CNT = AB_CNT_WIDTH'(32'd32);
    localparam logic [AB_CNT_WIDTH-1:0] AB_MAX_CNT = {AB_CNT_WIDTH{1'b1}};
    localparam logic [AB_CNT_WIDTH-1:0] AB_ONE     = AB_CNT_WIDTH'(32'd1);

    // Synchronizer
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;

    // Auto-baud engine
    logic [1:0]              ab_state_q, ab_state_d;
    logic [AB_CNT_WIDTH-1:0] ab_cnt_q, ab_cnt_d;
    logic                    ab_load_s;
    logic                    ab_err_s;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    // Active divisor
    logic [DIV_INT_WIDTH-1:0] div_int_q, div_int_d;
    logic [3:0]               div_frac_q, div_frac_d;
    logic                     div_change_s;

    // Generator
    logic [DIV_INT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]               frac_acc_q, frac_acc_d;
    logic [3:0]               tick_cnt_q, tick_cnt_d;
    logic [4:0]               frac_sum_s;
    logic [DIV_INT_WIDTH:0]   period_s;
    logic [DIV_INT_WIDTH:0]   cnt_next_s;
    logic                     last_s;
    logic                     hold_s;
    logic                     rx_pulse_s;
    logic                     tx_pulse_s;

    // Two-stage synchronizer input for the serial line.
    always_comb begin
        rx_meta_d = UART_RX;
        rx_s_d    = rx_meta_q;
    end

    // Auto-baud state machine and start-bit width counter.
    always_comb begin
        ab_state_d = ab_state_q;
        ab_cnt_d   = ab_cnt_q;
        ab_load_s  = 1'b0;
        ab_err_s   = 1'b0;
        case (ab_state_q)
            AB_IDLE: begin
                if (autobaud_start) begin
                    ab_state_d = AB_ARM;
                end else begin
                    ab_state_d = AB_IDLE;
                end
            end
            AB_ARM: begin
                // Wait for idle-high first so a line that is already low is
                // never measured from the middle of a low period.
                if (rx_s_q) begin
                    ab_state_d = AB_WAIT_FALL;
                end else begin
                    ab_state_d = AB_ARM;
                end
            end
            AB_WAIT_FALL: begin
                if (!rx_s_q) begin
                    ab_state_d = AB_MEASURE;
                    ab_cnt_d   = AB_ONE;
                end else begin
                    ab_state_d = AB_WAIT_FALL;
                end
            end
            AB_MEASURE: begin
                if (rx_s_q) begin
                    ab_state_d = AB_IDLE;
                    if (ab_cnt_q >= AB_MIN_CNT) begin
                        ab_load_s = 1'b1;
                    end else begin
                        ab_err_s = 1'b1;
                    end
                end else if (ab_cnt_q == AB_MAX_CNT) begin
                    ab_state_d = AB_IDLE;
                    ab_err_s   = 1'b1;
                end else begin
                    ab_cnt_d = ab_cnt_q + AB_ONE;
                end
            end
            default: begin
                ab_state_d = AB_IDLE;
            end
        endcase
        busy_d = (ab_state_d != AB_IDLE);
        done_d = ab_load_s;
        err_d  = ab_err_s;
    end

    // Active divisor selection; a software load overrides an auto-baud result.
    always_comb begin
        div_int_d    = div_int_q;
        div_frac_d   = div_frac_q;
        div_change_s = div_load | ab_load_s;
        if (div_load) begin
            div_int_d  = div_int;
            div_frac_d = div_frac;
        end else if (ab_load_s) begin
            div_int_d  = DIV_INT_WIDTH'(ab_cnt_q >> 4);
            div_frac_d = ab_cnt_q[3:0];
        end else begin
            div_int_d  = div_int_q;
            div_frac_d = div_frac_q;
        end
    end

    // Fractional divider: a period is one cycle longer whenever the
    // sixteenths accumulator overflows.
    always_comb begin
        frac_sum_s = {1'b0, frac_acc_q} + {1'b0, div_frac_q};
        period_s   = {1'b0, div_int_q} + {{DIV_INT_WIDTH{1'b0}}, frac_sum_s[4]};
        cnt_next_s = {1'b0, cnt_q} + {{DIV_INT_WIDTH{1'b0}}, 1'b1};
        last_s     = (cnt_next_s == period_s);
        hold_s     = ~baud_en | (div_int_q == {DIV_INT_WIDTH{1'b0}}) | div_change_s;

        cnt_d      = cnt_q;
        frac_acc_d = frac_acc_q;
        tick_cnt_d = tick_cnt_q;
        rx_pulse_s = 1'b0;
        tx_pulse_s = 1'b0;
        if (hold_s) begin
            cnt_d      = {DIV_INT_WIDTH{1'b0}};
            frac_acc_d = 4'd0;
            tick_cnt_d = 4'd0;
        end else if (last_s) begin
            cnt_d      = {DIV_INT_WIDTH{1'b0}};
            frac_acc_d = frac_sum_s[3:0];
            tick_cnt_d = tick_cnt_q + 4'd1;
            rx_pulse_s = 1'b1;
            tx_pulse_s = (tick_cnt_q == 4'd15);
        end else begin
            cnt_d = cnt_next_s[DIV_INT_WIDTH-1:0];
        end
    end

    // State registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            ab_state_q <= AB_IDLE;
            ab_cnt_q   <= {AB_CNT_WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            div_int_q  <= DIV_INT_WIDTH'(DEFAULT_DIV_INT);
            div_frac_q <= 4'(DEFAULT_DIV_FRAC);
            cnt_q      <= {DIV_INT_WIDTH{1'b0}};
            frac_acc_q <= 4'd0;
            tick_cnt_q <= 4'd0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            ab_state_q <= ab_state_d;
            ab_cnt_q   <= ab_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            cnt_q      <= cnt_d;
            frac_acc_q <= frac_acc_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Strobes are gated by the hold condition so disabling or reloading
    // suppresses them in the same cycle.
    always_comb begin
        rx_sample_pulse = rx_pulse_s;
        tx_baud_pulse   = tx_pulse_s;
        autobaud_busy   = busy_q;
        autobaud_done   = done_q;
        autobaud_err    = err_q;
        div_int_active  = div_int_q;
        div_frac_active = div_frac_q;
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;

    logic        ACLK;
    logic        ARESETn;
    logic        baud_en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        UART_RX;
    logic        autobaud_start;
    logic        rx_sample_pulse;
    logic        tx_baud_pulse;
    logic        autobaud_busy;
    logic        autobaud_done;
    logic        autobaud_err;
    logic [15:0] div_int_active;
    logic [3:0]  div_frac_active;

    int checks;
    int errors;
    int exp_int;
    int exp_frac;

    uart_baud_gen dut (
        .ACLK            (ACLK),
        .ARESETn         (ARESETn),
        .baud_en         (baud_en),
        .div_int         (div_int),
        .div_frac        (div_frac),
        .div_load        (div_load),
        .UART_RX         (UART_RX),
        .autobaud_start  (autobaud_start),
        .rx_sample_pulse (rx_sample_pulse),
        .tx_baud_pulse   (tx_baud_pulse),
        .autobaud_busy   (autobaud_busy),
        .autobaud_done   (autobaud_done),
        .autobaud_err    (autobaud_err),
        .div_int_active  (div_int_active),
        .div_frac_active (div_frac_active)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Move to just after the next rising edge; inputs set here apply to that cycle.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reference: with divisor D+F/16, the k-th sample pulse ends k*D + floor(k*F/16)
    // cycles after the generator starts (cycle 1 = first running cycle); every
    // 16th sample pulse is also a bit pulse.
    task automatic check_gen(input int d, input int f, input int t0, input int t_end, input string name);
        int  k;
        int  next_t;
        logic exp_rx;
        logic exp_tx;
        k      = 1;
        next_t = d + f / 16;
        while (next_t < t0) begin
            k++;
            next_t = k * d + (k * f) / 16;
        end
        for (int t = t0; t <= t_end; t++) begin
            @(negedge ACLK);
            if (t == t0) begin
                checks++;
                if (div_int_active !== 16'(d) || div_frac_active !== 4'(f)) begin
                    errors++;
                    $display("FAIL %s divisor: got %0d/%0d expected %0d/%0d", name,
                             div_int_active, div_frac_active, d, f);
                end
            end
            exp_rx = (t == next_t);
            exp_tx = exp_rx && ((k % 16) == 0);
            checks++;
            if (rx_sample_pulse !== exp_rx) begin
                errors++;
                $display("FAIL %s rx_sample_pulse t=%0d: got %b expected %b", name, t, rx_sample_pulse, exp_rx);
            end
            checks++;
            if (tx_baud_pulse !== exp_tx) begin
                errors++;
                $display("FAIL %s tx_baud_pulse t=%0d: got %b expected %b", name, t, tx_baud_pulse, exp_tx);
            end
            if (exp_rx) begin
                k++;
                next_t = k * d + (k * f) / 16;
            end
            tick();
        end
    endtask

    // Software load in the current cycle; the next cycle is generator cycle 1.
    task automatic do_load(input int d, input int f, input string name);
        div_int  = 16'(d);
        div_frac = 4'(f);
        div_load = 1'b1;
        @(negedge ACLK);
        checks++;
        if (rx_sample_pulse !== 1'b0 || div_int_active !== 16'(exp_int) || div_frac_active !== 4'(exp_frac)) begin
            errors++;
            $display("FAIL %s load cycle: got pulse %b div %0d/%0d expected pulse 0 div %0d/%0d", name,
                     rx_sample_pulse, div_int_active, div_frac_active, exp_int, exp_frac);
        end
        tick();
        div_load = 1'b0;
        exp_int  = d;
        exp_frac = f;
    endtask

    // Pulse autobaud_start and let the engine reach the wait-for-fall state.
    task automatic ab_start(input string name);
        autobaud_start = 1'b1;
        @(negedge ACLK);
        checks++;
        if (autobaud_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy in start cycle: got %b expected 0", name, autobaud_busy);
        end
        tick();
        autobaud_start = 1'b0;
        @(negedge ACLK);
        checks++;
        if (autobaud_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy after start: got %b expected 1", name, autobaud_busy);
        end
        tick();
        repeat (3) tick();
    endtask

    // Drive a low pulse of len cycles and check the result three cycles after
    // the line returns high (two synchronizer stages plus the decision cycle).
    // Returns in generator cycle 3 counted from the result cycle.
    task automatic ab_pulse(input int len, input string name);
        logic ok;
        ok = (len >= 32);
        UART_RX = 1'b0;
        repeat (len) tick();
        UART_RX = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge ACLK);
            checks++;
            if (autobaud_done !== 1'b0 || autobaud_err !== 1'b0 || autobaud_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s early result j=%0d: got done %b err %b busy %b expected 0 0 1", name, j,
                         autobaud_done, autobaud_err, autobaud_busy);
            end
            tick();
        end
        if (ok) begin
            exp_int  = len / 16;
            exp_frac = len % 16;
        end
        @(negedge ACLK);
        checks++;
        if (autobaud_done !== ok || autobaud_err !== !ok || autobaud_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result len=%0d: got done %b err %b busy %b expected %b %b 0", name, len,
                     autobaud_done, autobaud_err, autobaud_busy, ok, !ok);
        end
        checks++;
        if (div_int_active !== 16'(exp_int) || div_frac_active !== 4'(exp_frac)) begin
            errors++;
            $display("FAIL %s divisor len=%0d: got %0d/%0d expected %0d/%0d", name, len,
                     div_int_active, div_frac_active, exp_int, exp_frac);
        end
        tick();
        @(negedge ACLK);
        checks++;
        if (autobaud_done !== 1'b0 || autobaud_err !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse width: got done %b err %b expected 0 0", name, autobaud_done, autobaud_err);
        end
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        @(negedge ACLK);
        checks++;
        if (rx_sample_pulse !== 1'b0 || tx_baud_pulse !== 1'b0 || autobaud_busy !== 1'b0 ||
            autobaud_done !== 1'b0 || autobaud_err !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got %b%b%b%b%b expected 00000", rx_sample_pulse, tx_baud_pulse,
                     autobaud_busy, autobaud_done, autobaud_err);
        end
        checks++;
        if (div_int_active !== 16'd27 || div_frac_active !== 4'd2) begin
            errors++;
            $display("FAIL reset divisor: got %0d/%0d expected 27/2", div_int_active, div_frac_active);
        end
        tick();
        ARESETn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            checks++;
            if (rx_sample_pulse !== 1'b0) begin
                errors++;
                $display("FAIL disabled pulse i=%0d: got %b expected 0", i, rx_sample_pulse);
            end
            tick();
        end
    endtask

    task automatic test_default_periods();
        baud_en = 1'b1;
        check_gen(27, 2, 1, 440, "default_27_2");
    endtask

    task automatic test_autobaud_err();
        ab_start("ab_err20");
        ab_pulse(20, "ab_err20");
        ab_start("ab_err_rand");
        ab_pulse($urandom_range(2, 31), "ab_err_rand");
    endtask

    task automatic test_load_4_0();
        do_load(4, 0, "load_4_0");
        check_gen(4, 0, 1, 140, "load_4_0");
    endtask

    task automatic test_random_loads();
        int d;
        int f;
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(1, 12);
            f = $urandom_range(0, 15);
            do_load(d, f, "rand_load");
            check_gen(d, f, 1, 16 * d + f + $urandom_range(0, 9), "rand_load");
        end
    endtask

    task automatic test_baud_en_drop();
        do_load(5, 3, "en_drop");
        check_gen(5, 3, 1, $urandom_range(20, 60), "en_drop_pre");
        baud_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            checks++;
            if (rx_sample_pulse !== 1'b0 || tx_baud_pulse !== 1'b0) begin
                errors++;
                $display("FAIL en_drop halted i=%0d: got %b %b expected 0 0", i, rx_sample_pulse, tx_baud_pulse);
            end
            tick();
        end
        baud_en = 1'b1;
        check_gen(5, 3, 1, 120, "en_drop_post");
    endtask

    task automatic test_autobaud_868();
        ab_start("ab_868");
        ab_pulse(868, "ab_868");
        check_gen(54, 4, 3, 16 * 54 + 4 + 10, "ab_868_gen");
    endtask

    task automatic test_autobaud_random();
        int len;
        len = $urandom_range(32, 600);
        ab_start("ab_rand");
        ab_pulse(len, "ab_rand");
        check_gen(len / 16, len % 16, 3, 16 * (len / 16) + len % 16 + 5, "ab_rand_gen");
    endtask

    task automatic test_autobaud_prelow();
        UART_RX = 1'b0;
        repeat (5) tick();
        autobaud_start = 1'b1;
        tick();
        autobaud_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            checks++;
            if (autobaud_busy !== 1'b1 || autobaud_done !== 1'b0 || autobaud_err !== 1'b0) begin
                errors++;
                $display("FAIL prelow armed i=%0d: got busy %b done %b err %b expected 1 0 0", i,
                         autobaud_busy, autobaud_done, autobaud_err);
            end
            tick();
        end
        UART_RX = 1'b1;
        repeat (6) tick();
        ab_pulse(100, "ab_prelow");
        check_gen(6, 4, 3, 120, "ab_prelow_gen");
    endtask

    task automatic test_reset_mid_measure();
        ab_start("rst_mid");
        UART_RX = 1'b0;
        repeat (50) tick();
        ARESETn = 1'b0;
        UART_RX = 1'b1;
        @(negedge ACLK);
        checks++;
        if (autobaud_busy !== 1'b0 || rx_sample_pulse !== 1'b0 || tx_baud_pulse !== 1'b0 ||
            autobaud_done !== 1'b0 || autobaud_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid outputs: got busy %b rx %b tx %b done %b err %b expected all 0",
                     autobaud_busy, rx_sample_pulse, tx_baud_pulse, autobaud_done, autobaud_err);
        end
        checks++;
        if (div_int_active !== 16'd27 || div_frac_active !== 4'd2) begin
            errors++;
            $display("FAIL rst_mid divisor: got %0d/%0d expected 27/2", div_int_active, div_frac_active);
        end
        tick();
        tick();
        ARESETn  = 1'b1;
        exp_int  = 27;
        exp_frac = 2;
        check_gen(27, 2, 1, 60, "rst_mid_gen");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        exp_int        = 27;
        exp_frac       = 2;
        ARESETn        = 1'b0;
        baud_en        = 1'b0;
        div_int        = 16'd0;
        div_frac       = 4'd0;
        div_load       = 1'b0;
        UART_RX        = 1'b1;
        autobaud_start = 1'b0;

        test_reset();
        test_default_periods();
        test_autobaud_err();
        test_load_4_0();
        test_random_loads();
        test_baud_en_drop();
        test_autobaud_868();
        test_autobaud_random();
        test_autobaud_prelow();
        test_reset_mid_measure();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

UART baud-rate generator with auto-baud detection, directly upstream of the UART receiver and transmitter. It divides ACLK by a programmable integer-plus-sixteenths divisor to produce the 16x oversampling strobe `rx_sample_pulse`, and a 1x bit strobe `tx_baud_pulse`. An optional auto-baud engine measures the start-bit width of an incoming 0x55 character and loads the divisor automatically.

## Interface
Parameters:
- DIV_INT_WIDTH, 16, width of integer divisor (ACLK cycles per sample pulse)
- DEFAULT_DIV_INT, 27, reset value of active integer divisor
- DEFAULT_DIV_FRAC, 2, reset value of active fractional divisor (sixteenths)
- AB_CNT_WIDTH, DIV_INT_WIDTH+4, auto-baud measurement counter width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- baud_en  in  1  generator enable; low clears and halts counters
- div_int  in  DIV_INT_WIDTH  software integer divisor
- div_frac  in  4  software fractional divisor, in 1/16 units
- div_load  in  1  one-cycle pulse; latch div_int/div_frac into active divisor
- UART_RX  in  1  asynchronous serial line, idle high
- autobaud_start  in  1  one-cycle pulse; arm auto-baud measurement
- rx_sample_pulse  out  1  16x oversample strobe, one cycle wide
- tx_baud_pulse  out  1  1x bit strobe, coincident with every 16th rx_sample_pulse
- autobaud_busy  out  1  auto-baud FSM not idle
- autobaud_done  out  1  one-cycle pulse; measurement succeeded
- autobaud_err  out  1  one-cycle pulse; measurement rejected
- div_int_active  out  DIV_INT_WIDTH  active integer divisor
- div_frac_active  out  4  active fractional divisor

## Operation
- Active divisor `{div_int_active, div_frac_active}` is loaded by `div_load` or by auto-baud success. If both occur in the same cycle, `div_load` values win; `autobaud_done` still pulses.
- Generator state: cycle counter, 4-bit `frac_acc`, 4-bit `tick_cnt`.
- Period length is `div_int_active + c`, where `c` is the carry of `frac_acc + div_frac_active` (4-bit add).
- On the last cycle of each period:
  - `rx_sample_pulse` = 1.
  - `frac_acc` <= the sum mod 16.
  - `tick_cnt` increments and wraps 15->0.
  - `tx_baud_pulse` = 1 when `tick_cnt` == 15 at that point.
- Every 16 sample pulses span exactly `16*div_int_active + div_frac_active` cycles.
- Generator is held cleared (all counters 0, no pulses) when any of these holds:
  - `baud_en` = 0
  - `div_int_active` = 0
  - the active divisor changes (`div_load` or auto-baud load); clear applies in the load cycle.
- UART_RX passes through a 2-flop synchronizer, reset value 1. Auto-baud uses only the synchronized value `rx_s`.
- Auto-baud FSM:
  - AB_IDLE: `autobaud_start` -> AB_ARM.
  - AB_ARM: `rx_s` = 1 -> AB_WAIT_FALL. Prevents measuring from mid-low.
  - AB_WAIT_FALL: `rx_s` = 0 -> AB_MEASURE, with `ab_cnt` = 1.
  - AB_MEASURE: while `rx_s` = 0, `ab_cnt` increments.
    - `rx_s` = 1 with `ab_cnt` >= 32 -> load `div_int_active` = `ab_cnt[AB_CNT_WIDTH-1:4]` and `div_frac_active` = `ab_cnt[3:0]`; pulse `autobaud_done`; -> AB_IDLE.
    - `rx_s` = 1 with `ab_cnt` < 32 -> pulse `autobaud_err`; divisor unchanged; -> AB_IDLE.
    - `ab_cnt` reaching all-ones while `rx_s` = 0 -> pulse `autobaud_err`; -> AB_IDLE.
- `autobaud_start` is ignored while busy. The generator keeps running on the old divisor during measurement.
- `autobaud_busy` = 1 in every state except AB_IDLE.

## Timing
- Reset values:
  - `rx_sample_pulse`, `tx_baud_pulse`, `autobaud_busy`, `autobaud_done`, `autobaud_err` = 0
  - `div_int_active` = DEFAULT_DIV_INT, `div_frac_active` = DEFAULT_DIV_FRAC
  - FSM = AB_IDLE; synchronizer = 1
- First `rx_sample_pulse` occurs `div_int_active + c` cycles after the first cycle in which the generator is not held cleared. That cycle counts as cycle 1.
- `div_load` in cycle N: active outputs show new values in cycle N+1, and counting restarts from N+1.
- Synchronizer latency is 2 cycles on both edges. The measured count equals the UART_RX low width in ACLK cycles.
- `autobaud_done`/`autobaud_err` assert in the cycle after `rx_s` is first seen high. Active divisor outputs update in the same cycle as `autobaud_done`.
- `autobaud_busy` asserts the cycle after `autobaud_start` and deasserts in the `done`/`err` cycle.
- Reset mid-operation: all state returns to reset values immediately; no pulses are emitted.

## Test plan
- `div_load` int=4 frac=0, `baud_en`=1 -> `rx_sample_pulse` every 4 cycles; `tx_baud_pulse` every 64 cycles, coincident with each 16th sample pulse.
- Reset defaults (27/2), `baud_en`=1 -> 16 sample periods total 434 cycles; periods 8 and 16 are 28 cycles, all others 27.
- `autobaud_start`, then UART_RX low for 868 cycles -> `autobaud_done` pulse, `div_int_active`=54, `div_frac_active`=4; generator restarts with 54-cycle periods, 55 on carry.
- `autobaud_start`, UART_RX low for 20 cycles -> `autobaud_err`; divisor stays 27/2.
- `autobaud_start` with UART_RX already low -> FSM stays in AB_ARM (`autobaud_busy`=1) until the line goes high; then a 100-cycle low pulse -> done, int=6, frac=4.
- `div_load` mid-period and `baud_en` dropped mid-bit -> counters restart (next pulse exactly `div_int` cycles after load) / pulses stop immediately. ARESETn asserted during AB_MEASURE -> `busy`=0, divisor returns to defaults.
